// File: rtl/change_dispenser.sv
// Change payout stage: captures the owed balance once per purchase and pays it out
// greedily (5/2/1 units) one coin at a time over a req/ack hopper handshake.
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dispense,
  input  logic [3:0] balance,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [1:0] coin_type,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] remaining,
  output logic [2:0] coins_paid
);

  typedef enum logic [2:0] {StIdle, StReq, StGap, StRelease, StFault} state_e;

  localparam logic [7:0] CntLast = 8'(ACK_TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [3:0] rem_after_ack;

  function automatic logic [1:0] pick_coin(input logic [3:0] amt);
    if (amt >= 4'd5) begin
      return 2'b11;
    end else if (amt >= 4'd2) begin
      return 2'b10;
    end
    return 2'b01;
  endfunction

  function automatic logic [3:0] coin_value(input logic [1:0] t);
    logic [3:0] v;
    case (t)
      2'b11:   v = 4'd5;
      2'b10:   v = 4'd2;
      2'b01:   v = 4'd1;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

  // Greedy choice guarantees the coin never exceeds the amount still owed.
  always_comb begin
    rem_after_ack = remaining - coin_value(coin_type);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      coin_req   <= 1'b0;
      coin_type  <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      remaining  <= 4'd0;
      coins_paid <= 3'd0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dispense) begin
            remaining  <= balance;
            coins_paid <= 3'd0;
            cnt_q      <= 8'd0;
            if (balance == 4'd0) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= StRelease;
            end else begin
              busy      <= 1'b1;
              coin_req  <= 1'b1;
              coin_type <= pick_coin(balance);
              state_q   <= StReq;
            end
          end
        end
        StReq: begin
          // An ack on the timeout edge still wins.
          if (coin_ack) begin
            remaining  <= rem_after_ack;
            coins_paid <= coins_paid + 3'd1;
            coin_req   <= 1'b0;
            coin_type  <= 2'b00;
            cnt_q      <= 8'd0;
            if (rem_after_ack == 4'd0) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= StRelease;
            end else begin
              state_q <= StGap;
            end
          end else if (cnt_q == CntLast) begin
            coin_req  <= 1'b0;
            coin_type <= 2'b00;
            fault     <= 1'b1;
            state_q   <= StFault;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StGap: begin
          coin_req  <= 1'b1;
          coin_type <= pick_coin(remaining);
          state_q   <= StReq;
        end
        StRelease: begin
          // Wait for the strobe to drop so a held dispense is not captured twice.
          if (!dispense) begin
            state_q <= StIdle;
          end
        end
        StFault: begin
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
